// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: two write ports, two
// combinational read ports, the clear-busy flag and the write-collision flag.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we0;
  logic [ADDR_W-1:0] waddr0;
  logic [DATA_W-1:0] wdata0;
  logic              we1;
  logic [ADDR_W-1:0] waddr1;
  logic [DATA_W-1:0] wdata1;
  logic [ADDR_W-1:0] raddr0;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              busy;
  logic              wr_conflict;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr0, raddr1,
    input  rdata0, rdata1, busy, wr_conflict
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr0, raddr1,
    output rdata0, rdata1, busy, wr_conflict
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised 2-write / 2-read register file with optional hardwired-zero
// entry 0, a post-reset clear sequencer and a registered write-collision flag.
// Optional feature: define REGFILE_MP_BYPASS_EN to forward same-cycle write
// data to the read ports (write-before-read). Default build reads old data.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              idle;
  logic              wr0_ok, wr1_ok, same_addr;
  logic              wr_conflict_q;

  assign idle      = (state == IDLE);
  assign same_addr = (bus.waddr0 == bus.waddr1);
  // Writes to entry 0 are dropped when it is hardwired to zero.
  assign wr0_ok    = idle && bus.we0 && !(ZERO_REG != 0 && bus.waddr0 == '0);
  assign wr1_ok    = idle && bus.we1 && !(ZERO_REG != 0 && bus.waddr1 == '0);

  // Read mux: stored value, optional forwarding, then zero-reg and busy overrides.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] r;
    r = mem[ra];
`ifdef REGFILE_MP_BYPASS_EN
    if (idle && bus.we0 && bus.waddr0 == ra) r = bus.wdata0;
    if (idle && bus.we1 && bus.waddr1 == ra) r = bus.wdata1;
`endif
    if (ZERO_REG != 0 && ra == '0) r = '0;
    if (!idle) r = '0;
    return r;
  endfunction

  // Sequencer state register; reset restarts the clear from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Sequencer next state: walk every entry once, then stay in IDLE.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    if (state == CLEAR) begin
      clr_cnt_nxt = clr_cnt + 1'b1;
      if (clr_cnt == '1) state_nxt = IDLE;
    end
  end

  // Storage update: clear entries while busy, otherwise the two write ports
  // with port 1 winning a same-address collision. Nothing changes on a reset edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
      end else begin
        if (wr0_ok && !(wr1_ok && same_addr)) mem[bus.waddr0] <= bus.wdata0;
        if (wr1_ok) mem[bus.waddr1] <= bus.wdata1;
      end
    end
  end

  // Collision flag: one-cycle pulse after a same-address dual write in IDLE,
  // including collisions on a hardwired-zero entry 0.
  always_ff @(posedge clk) begin
    if (rst) wr_conflict_q <= 1'b0;
    else     wr_conflict_q <= idle && bus.we0 && bus.we1 && same_addr;
  end

  // Combinational read ports and status outputs.
  always_comb begin
    bus.rdata0      = read_port(bus.raddr0);
    bus.rdata1      = read_port(bus.raddr1);
    bus.busy        = (state == CLEAR);
    bus.wr_conflict = wr_conflict_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a default instance (32x32, zero reg) and a
// small instance (8 entries, entry 0 ordinary). Stimulus pushes expectations;
// a negedge monitor pops and compares them.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus   ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(3)) bus_s ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  regfile_mp #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s)
  );

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0:       return bus.rdata0;
      1:       return bus.rdata1;
      2:       return {31'd0, bus.busy};
      3:       return {31'd0, bus.wr_conflict};
      4:       return bus_s.rdata0;
      default: return {31'd0, bus_s.busy};
    endcase
  endfunction

  task automatic expect_val(input int sel, input logic [31:0] v, input string nm);
    chk_t c;
    c.sel  = sel;
    c.exp  = v;
    c.name = nm;
    q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every pending expectation mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t        c;
      logic [31:0] act;
      c   = q.pop_front();
      act = pick(c.sel);
      n_chk++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h at %0t", c.name, act, c.exp, $time);
      end
    end
  end

  task automatic idle_inputs();
    bus.we0 = 0; bus.waddr0 = '0; bus.wdata0 = '0;
    bus.we1 = 0; bus.waddr1 = '0; bus.wdata1 = '0;
    bus.raddr0 = '0; bus.raddr1 = '0;
    bus_s.we0 = 0; bus_s.waddr0 = '0; bus_s.wdata0 = '0;
    bus_s.we1 = 0; bus_s.waddr1 = '0; bus_s.wdata1 = '0;
    bus_s.raddr0 = '0; bus_s.raddr1 = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;

    // Busy window: 32 cycles for the big instance, 8 for the small one.
    bus.raddr0 = 5'd5;
    for (int i = 0; i < 32; i++) begin
      expect_val(2, 32'd1, "busy_clear");
      expect_val(0, 32'd0, "rdata_forced_busy");
      expect_val(5, (i < 8) ? 32'd1 : 32'd0, "busy_small");
      tick();
    end
    expect_val(2, 32'd0, "busy_done");
    expect_val(3, 32'd0, "conflict_reset");

    // Every entry reads zero after the clear.
    for (int a = 0; a < 32; a++) begin
      bus.raddr0   = 5'(a);
      bus.raddr1   = 5'(31 - a);
      bus_s.raddr0 = 3'(a);
      expect_val(0, 32'd0, "cleared_r0");
      expect_val(1, 32'd0, "cleared_r1");
      expect_val(4, 32'd0, "cleared_small");
      tick();
    end

    // Single write, readback next cycle.
    bus.we0 = 1; bus.waddr0 = 5'd5; bus.wdata0 = 32'hDEADBEEF;
    tick();
    bus.we0 = 0; bus.raddr1 = 5'd5;
    expect_val(1, 32'hDEADBEEF, "write_readback");
    expect_val(3, 32'd0, "no_conflict_single");
    // Write to entry 0 is dropped.
    bus.we0 = 1; bus.waddr0 = 5'd0; bus.wdata0 = 32'h1234; bus.raddr0 = 5'd0;
    expect_val(0, 32'd0, "zero_reg_same_cycle");
    tick();
    bus.we0 = 0;
    expect_val(0, 32'd0, "zero_reg_after");
    tick();

    // Same-address dual write: port 1 wins, one-cycle conflict pulse.
    bus.we0 = 1; bus.waddr0 = 5'd7; bus.wdata0 = 32'h11111111;
    bus.we1 = 1; bus.waddr1 = 5'd7; bus.wdata1 = 32'h22222222;
    bus.raddr0 = 5'd7;
    expect_val(0, BYP ? 32'h22222222 : 32'd0, "collide_same_cycle");
    tick();
    bus.we0 = 0; bus.we1 = 0;
    expect_val(0, 32'h22222222, "collide_port1_wins");
    expect_val(3, 32'd1, "conflict_pulse");
    tick();
    expect_val(3, 32'd0, "conflict_one_cycle");

    // Dual write to distinct addresses: both land, no conflict.
    bus.we0 = 1; bus.waddr0 = 5'd10; bus.wdata0 = 32'hA5A5A5A5;
    bus.we1 = 1; bus.waddr1 = 5'd11; bus.wdata1 = 32'h5A5A5A5A;
    tick();
    bus.we0 = 0; bus.we1 = 0; bus.raddr0 = 5'd10; bus.raddr1 = 5'd11;
    expect_val(0, 32'hA5A5A5A5, "dual_w0");
    expect_val(1, 32'h5A5A5A5A, "dual_w1");
    expect_val(3, 32'd0, "dual_no_conflict");
    tick();

    // Collision on entry 0 still flags.
    bus.we0 = 1; bus.waddr0 = 5'd0; bus.wdata0 = 32'h1;
    bus.we1 = 1; bus.waddr1 = 5'd0; bus.wdata1 = 32'h2;
    tick();
    bus.we0 = 0; bus.we1 = 0; bus.raddr0 = 5'd0;
    expect_val(3, 32'd1, "conflict_addr0");
    expect_val(0, 32'd0, "addr0_still_zero");
    tick();

    // Same-cycle read/write of entry 9 (old 1, new 2).
    bus.we0 = 1; bus.waddr0 = 5'd9; bus.wdata0 = 32'h1;
    tick();
    bus.raddr0 = 5'd9; bus.wdata0 = 32'h2;
    expect_val(0, BYP ? 32'h2 : 32'h1, "rw_same_cycle");
    tick();
    bus.we0 = 0;
    expect_val(0, 32'h2, "rw_next_cycle");

    // Both ports targeting the read address: port 1 forwarded when bypassing.
    bus.we0 = 1; bus.waddr0 = 5'd12; bus.wdata0 = 32'h3;
    bus.we1 = 1; bus.waddr1 = 5'd12; bus.wdata1 = 32'h4;
    bus.raddr1 = 5'd12;
    expect_val(1, BYP ? 32'h4 : 32'h0, "bypass_priority");
    tick();
    bus.we0 = 0; bus.we1 = 0;
    expect_val(1, 32'h4, "prio_stored");

    // Small instance: entry 0 is an ordinary register.
    bus_s.we0 = 1; bus_s.waddr0 = 3'd0; bus_s.wdata0 = 32'h55;
    tick();
    bus_s.we0 = 0; bus_s.raddr0 = 3'd0;
    expect_val(4, 32'h55, "small_addr0_write");
    tick();

    // Reset mid-clear: full restart, writes ignored while busy and on reset edges.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      expect_val(2, 32'd1, "busy_before_reclear");
      tick();
    end
    rst = 1'b1;
    bus.we0 = 1; bus.waddr0 = 5'd3; bus.wdata0 = 32'hAAAA;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      expect_val(2, 32'd1, "busy_restart");
      tick();
    end
    bus.we0 = 0;
    bus.raddr0 = 5'd3; bus.raddr1 = 5'd5;
    expect_val(2, 32'd0, "busy_restart_done");
    expect_val(0, 32'd0, "write_during_busy_ignored");
    expect_val(1, 32'd0, "reclear_entry5");
    tick();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-cycle datapath's 32x32 register file.
- 2 write ports, 2 combinational read ports, configurable width/depth, hardwired-zero register 0.
- Hardware clear sequencer that zeroes every entry after reset, with a busy indication.
- Registered write-collision flag for the dual-issue datapath's hazard logic.

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
we0  in  1  write enable, port 0
waddr0  in  ADDR_W  write address, port 0
wdata0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1
waddr1  in  ADDR_W  write address, port 1
wdata1  in  DATA_W  write data, port 1
raddr0  in  ADDR_W  read address, port 0
raddr1  in  ADDR_W  read address, port 1
rdata0  out  DATA_W  read data, port 0, combinational
rdata1  out  DATA_W  read data, port 1, combinational
busy  out  1  high while the clear sequencer runs; writes ignored
wr_conflict  out  1  registered pulse: the previous cycle had a same-address dual write

Behaviour:
- Storage: 2**ADDR_W x DATA_W array. Contents are not initialised by initial blocks; the clear sequencer defines them.
- Sync reset (rst=1 at posedge):
  - state <= CLEAR, clr_cnt <= 0, wr_conflict <= 0.
  - Array contents are untouched on the reset edge itself.
- States:
  - CLEAR: each cycle, mem[clr_cnt] <= 0 and clr_cnt <= clr_cnt+1. When clr_cnt == 2**ADDR_W-1, that entry is cleared and state <= IDLE. Duration is exactly 2**ADDR_W cycles after reset deasserts.
  - IDLE: normal operation. No path returns to CLEAR except rst.
- busy = (state == CLEAR); combinational from the state register. busy is 1 in the cycle after any reset edge.
- Reset mid-clear: the sequencer restarts at clr_cnt=0 and runs the full clear again.
- Writes:
  - Accepted only in IDLE. we0/we1 are ignored while busy, and also on any edge where rst=1.
  - Port k writes wdata_k to mem[waddr_k] at posedge when we_k=1.
  - Same-address dual write (we0 & we1 & waddr0==waddr1): port 1 wins and port 0's data is discarded. wr_conflict <= 1 for exactly the next cycle, otherwise 0.
  - wr_conflict is also asserted when the colliding address is 0 with ZERO_REG=1.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Reads:
  - Asynchronous: rdata_k = mem[raddr_k], updated whenever the address or the addressed entry changes.
  - With ZERO_REG=1 and raddr_k==0, rdata_k = 0.
  - While busy, both rdata outputs are forced to 0.
  - Default (no bypass): a read of an address written in the same cycle returns the old value; the new value is visible the cycle after the edge.
- Width rules: addresses are full-range, with no out-of-range case. Data is stored unmodified.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined: each read port forwards same-cycle write data combinationally (write-before-read).
  - If raddr_k matches an enabled write port's address in IDLE, rdata_k = that port's wdata.
  - When both ports match, port 1 has priority, consistent with the write priority.
  - Bypass never overrides the ZERO_REG read of address 0 or the busy-forced 0.
- Undefined: no forwarding; read-before-write as described in Behaviour.

Test Plan:
1. Reset 1 cycle, then release -> busy=1 for exactly 32 cycles, then 0. A subsequent read of every address returns 0x00000000.
2. In IDLE, we0=1 waddr0=5 wdata0=0xDEADBEEF; next cycle raddr1=5 -> rdata1=0xDEADBEEF, wr_conflict=0. Write to address 0 with 0x1234 -> rdata0 at raddr0=0 stays 0.
3. Same cycle: we0=1 waddr0=7 wdata0=0x11111111 and we1=1 waddr1=7 wdata1=0x22222222 -> mem[7]=0x22222222. wr_conflict=1 for exactly one cycle.
4. Assert rst at clear cycle 10 -> sequencer restarts and busy stays high 32 more cycles. A write (we0=1, addr 3, 0xAAAA) during busy is ignored, so addr 3 reads 0 afterwards.
5. Same-cycle read/write of addr 9 (old 0x1, new 0x2):
   - Without REGFILE_MP_BYPASS_EN: rdata0=0x1 in that cycle, 0x2 next cycle.
   - With the macro: rdata0=0x2 in the same cycle.
6. ZERO_REG=0, ADDR_W=3 build -> clear lasts 8 cycles. Writing 0x55 to addr 0 reads back 0x55.
